icache_fetcher: RTL



---
 rtl/icache_fetcher_pkg.sv | 15 +
 rtl/icache_array.sv | 48 ++++
 rtl/icache_fetcher.sv | 132 +++++++++++++
 3 files changed

// File: rtl/icache_fetcher_pkg.sv
// rtl/icache_fetcher_pkg.sv - shared widths and FSM encoding for the instruction fetcher
package icache_fetcher_pkg;

  localparam int INS_WIDTH         = 32;
  localparam int ADDR_WIDTH        = 32;
  localparam int ICACHE_INDEX_BITS = 6;

  // GAP keeps mem_req low for one cycle after a fill so the controller settles
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_MISS = 2'd1,
    IF_GAP  = 2'd2
  } if_state_t;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped one-word-per-line valid/tag/data storage
module icache_array
  import icache_fetcher_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = ADDR_WIDTH - ICACHE_INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  hit,
  output logic [INS_WIDTH-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [INS_WIDTH-1:0]  wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tags [LINES];
  logic [INS_WIDTH-1:0] data [LINES];

  // Combinational lookup; fills never overlap a lookup, so no bypass path
  always_comb begin
    hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
    rd_data = data[rd_index];
  end

  // Valid bits: cleared together on reset, set line by line on fill
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload need no reset; valid gates their use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_fetcher.sv
// rtl/icache_fetcher.sv - PC, miss FSM and decode-side output registers
module icache_fetcher
  import icache_fetcher_pkg::*;
#(
  parameter int                    INDEX_BITS = ICACHE_INDEX_BITS,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  mem_done,
  input  logic [INS_WIDTH-1:0]  mem_ins,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  stall_in,
  output logic                  ins_valid,
  output logic [INS_WIDTH-1:0]  ins,
  output logic [ADDR_WIDTH-1:0] ins_pc
);
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  if_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  ins_valid_d;
  logic [INS_WIDTH-1:0]  ins_d;
  logic [ADDR_WIDTH-1:0] ins_pc_d;
  logic                  fill_en;
  logic                  hit;
  logic [INS_WIDTH-1:0]  rd_data;
  logic                  out_free;
  logic                  consumed;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .clear_n  (rst),
    .rd_index (pc_q[INDEX_BITS+1:2]),
    .rd_tag   (pc_q[ADDR_WIDTH-1:INDEX_BITS+2]),
    .hit      (hit),
    .rd_data  (rd_data),
    .wr_en    (fill_en && rdy && rst),
    .wr_index (mem_addr[INDEX_BITS+1:2]),
    .wr_tag   (mem_addr[ADDR_WIDTH-1:INDEX_BITS+2]),
    .wr_data  (mem_ins)
  );

  // Next-state and output-register values; flush overrides every state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    ins_valid_d = ins_valid;
    ins_d       = ins;
    ins_pc_d    = ins_pc;
    fill_en     = 1'b0;
    out_free    = !ins_valid || !stall_in;
    consumed    = ins_valid && !stall_in;

    if (flush) begin
      pc_d        = flush_pc;
      ins_valid_d = 1'b0;
      mem_req_d   = 1'b0;
      state_d     = IF_IDLE;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (out_free) begin
            if (hit) begin
              ins_d       = rd_data;
              ins_pc_d    = pc_q;
              ins_valid_d = 1'b1;
              pc_d        = pc_q + 32'd4;
            end else begin
              ins_valid_d = 1'b0;
              mem_req_d   = 1'b1;
              mem_addr_d  = pc_q;
              state_d     = IF_MISS;
            end
          end
        end
        IF_MISS: begin
          if (consumed) begin
            ins_valid_d = 1'b0;
          end
          if (mem_done) begin
            fill_en   = 1'b1;
            mem_req_d = 1'b0;
            state_d   = IF_GAP;
          end
        end
        IF_GAP: begin
          if (consumed) begin
            ins_valid_d = 1'b0;
          end
          state_d = IF_IDLE;
        end
        default: begin
          state_d = IF_IDLE;
        end
      endcase
    end
  end

  // State and output registers; rdy low freezes everything except reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IF_IDLE;
      pc_q      <= RESET_PC;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ins_valid <= 1'b0;
      ins       <= '0;
      ins_pc    <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      ins_valid <= ins_valid_d;
      ins       <= ins_d;
      ins_pc    <= ins_pc_d;
    end
  end

endmodule
